// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 24C02-style serial EEPROM, oversampling SCL/SDA on clk.
// Latency: a pin transition reaches sda_oe_o 3 clk cycles later (2-flop sync + registered output).
// Backpressure: none; never stretches SCL, ACKs every byte once the device address matches.
module i2c_eeprom_slave #(
    parameter logic [6:0] ADDRESS   = 7'b1010_000,
    parameter int         MEM_BYTES = 256,
    parameter int         PAGE_SIZE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o,
    output logic busy_o
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_ACK_DEV,
        ST_WADDR,
        ST_ACK_WADDR,
        ST_WDATA,
        ST_ACK_WDATA,
        ST_RDATA,
        ST_RACK,
        ST_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      scl_sync_q, scl_sync_d;
    logic [2:0]      sda_sync_q, sda_sync_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            rw_q, rw_d;
    logic            mack_q, mack_d;

    // Storage holds the complement of each byte so that a zero-initialised
    // array (FPGA bitstream default, simulator power-up) reads as erased 8'hFF.
    logic [7:0]      mem_n_q [MEM_BYTES];
    logic            mem_we;
    logic [7:0]      rd_byte;
    logic [AW-1:0]   ptr_page_nxt;

    logic scl_now, scl_prv, sda_now, sda_prv;
    logic scl_rise, scl_fall, start_det, stop_det;

    // [0],[1] form the synchronizer; [2] is the previous synchronized sample.
    assign scl_now   = scl_sync_q[1];
    assign scl_prv   = scl_sync_q[2];
    assign sda_now   = sda_sync_q[1];
    assign sda_prv   = sda_sync_q[2];
    assign scl_rise  = scl_now & ~scl_prv;
    assign scl_fall  = ~scl_now & scl_prv;
    assign start_det = scl_now & scl_prv & sda_prv & ~sda_now;
    assign stop_det  = scl_now & scl_prv & ~sda_prv & sda_now;

    assign rd_byte      = ~mem_n_q[ptr_q];
    // Write pointer stays inside its page: keep upper bits, wrap the low bits.
    assign ptr_page_nxt = (ptr_q & ~PAGE_MASK) | ((ptr_q + 1'b1) & PAGE_MASK);

    assign sda_oe_o = sda_oe_q;
    assign busy_o   = busy_q;

    // State register and synchronizers; the bus idles high so sync flops reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
        end
    end

    // Memory write port; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_n_q[ptr_q] <= ~shift_q;
        end
    end

    // Next-state logic: START/STOP override everything, otherwise walk the byte protocol.
    always_comb begin
        state_d    = state_q;
        scl_sync_d = {scl_sync_q[1:0], scl_i};
        sda_sync_d = {sda_sync_q[1:0], sda_i};
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        mem_we     = 1'b0;

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_DEV, ST_WADDR, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_now};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == ST_DEV) begin
                            if (shift_q[7:1] == ADDRESS) begin
                                state_d  = ST_ACK_DEV;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d  = ST_IDLE;
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                            end
                        end else if (state_q == ST_WADDR) begin
                            state_d  = ST_ACK_WADDR;
                            ptr_d    = shift_q[AW-1:0];
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = ST_ACK_WDATA;
                            mem_we   = 1'b1;
                            ptr_d    = ptr_page_nxt;
                            sda_oe_d = 1'b1;
                        end
                    end
                end
                ST_ACK_DEV, ST_ACK_WADDR, ST_ACK_WDATA: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (state_q == ST_ACK_DEV && rw_q) begin
                            state_d  = ST_RDATA;
                            shift_d  = rd_byte;
                            ptr_d    = ptr_q + 1'b1;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = (state_q == ST_ACK_DEV) ? ST_WADDR : ST_WDATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ST_RACK;
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        mack_d = ~sda_now;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (mack_q) begin
                            state_d  = ST_RDATA;
                            shift_d  = rd_byte;
                            ptr_d    = ptr_q + 1'b1;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = ST_WAIT;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: begin
                    // IDLE and WAIT only leave on START/STOP, handled above.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, array reference model, queue scoreboard.
// Latency: master samples SDA mid SCL-high, well after the slave's 3-cycle output latency.
// Backpressure: none; the monitor drains observed ACK/data events as soon as they appear.
module tb_i2c_eeprom_slave;

    localparam int H = 8;   // SCL high/low phase in clk cycles
    localparam int Q = 4;   // SDA changes this many cycles after SCL falls

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_i, sda_i;
    logic sda_oe_o, busy_o;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe_o;   // open-drain wired-AND

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .ADDRESS   (7'b1010_000),
        .MEM_BYTES (256),
        .PAGE_SIZE (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_oe_o (sda_oe_o),
        .busy_o   (busy_o)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256];
    int         ref_ptr;

    // bit 8: 1 = read data byte, 0 = ACK observation (bit 0 = 1 means ACKed)
    logic [8:0] exp_q [$];
    logic [8:0] obs_q [$];
    string      tag_q [$];

    int oe_cnt = 0;
    int busy_cnt = 0;

    // Running counts of cycles with SDA pulled / busy asserted.
    always @(posedge clk) begin
        if (sda_oe_o) oe_cnt <= oe_cnt + 1;
        if (busy_o) busy_cnt <= busy_cnt + 1;
    end

    // Scoreboard monitor: compares every observed bus event against the oldest expectation.
    initial begin
        logic [8:0] o;
        logic [8:0] e;
        string      t;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %h, required no event", o);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL %s: got %h, required %h", t, o, e);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        cyc(Q);
        sda_m = b;
        cyc(Q);
        scl_m = 1'b1;
        cyc(H / 2);
        s = sda_i;
        cyc(H / 2);
        scl_m = 1'b0;
    endtask

    task automatic start_c;
        cyc(Q);
        sda_m = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        cyc(H);
        sda_m = 1'b0;
        cyc(H);
        scl_m = 1'b0;
    endtask

    task automatic stop_c;
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b1;
        cyc(H);
        sda_m = 1'b1;
        cyc(H);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic s;
        exp_q.push_back({8'h00, exp_ack});
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        obs_q.push_back({8'h00, ~s});
    endtask

    task automatic rd_byte(input logic ack, input string tag);
        logic [7:0] d;
        logic       s;
        exp_q.push_back({1'b1, ref_mem[ref_ptr]});
        tag_q.push_back(tag);
        ref_ptr = (ref_ptr + 1) % 256;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(~ack, s);
        obs_q.push_back({1'b1, d});
    endtask

    // START, device write, word address; leaves the bus mid-transaction.
    task automatic set_ptr(input logic [7:0] a);
        start_c;
        wr_byte(8'hA0, 1'b1, "dev_w_ack");
        check("busy_after_addr", busy_o, 1);
        wr_byte(a, 1'b1, "waddr_ack");
        ref_ptr = a;
    endtask

    // Page write of n bytes taken MSB-first from d.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int n);
        logic [7:0] b;
        set_ptr(a);
        for (int k = 0; k < n; k++) begin
            b = d[8*(n-1-k) +: 8];
            wr_byte(b, 1'b1, "wdata_ack");
            ref_mem[ref_ptr] = b;
            ref_ptr = (ref_ptr / 8) * 8 + ((ref_ptr % 8) + 1) % 8;
        end
        stop_c;
        check("busy_after_stop", busy_o, 0);
    endtask

    // (Repeated) START, device read, n bytes with the last one NACKed, STOP.
    task automatic do_read(input int n, input string tag);
        start_c;
        wr_byte(8'hA1, 1'b1, "dev_r_ack");
        for (int k = 0; k < n; k++) rd_byte(k != n - 1, tag);
        check("oe_after_nack", sda_oe_o, 0);
        stop_c;
        check("busy_after_rd_stop", busy_o, 0);
    endtask

    initial begin
        int         o0, b0, a, n;
        logic [31:0] d;
        logic       s;

        for (int k = 0; k < 256; k++) ref_mem[k] = 8'hFF;
        ref_ptr = 0;

        rst = 1'b1;
        cyc(3);
        check("reset_oe", sda_oe_o, 0);
        check("reset_busy", busy_o, 0);
        rst = 1'b0;
        cyc(4);

        // Byte write then random read
        do_write(8'h10, 32'h5A, 1);
        set_ptr(8'h10);
        do_read(1, "byte_rd");

        // Page write wrapping inside an 8-byte page
        do_write(8'h06, 32'h01020304, 4);
        set_ptr(8'h06);
        do_read(4, "page_rd06");
        set_ptr(8'h00);
        do_read(2, "page_rd00");

        // Sequential read wrapping at the top of memory
        set_ptr(8'hFE);
        do_read(3, "seq_wrap");

        // Address mismatch: no ACK, no drive, no busy
        o0 = oe_cnt;
        b0 = busy_cnt;
        start_c;
        wr_byte(8'hA2, 1'b0, "mismatch_ack");
        stop_c;
        cyc(2);
        check("mismatch_oe_cycles", oe_cnt - o0, 0);
        check("mismatch_busy_cycles", busy_cnt - b0, 0);

        // Reset while the slave drives the 0 MSB of 5A
        set_ptr(8'h10);
        start_c;
        wr_byte(8'hA1, 1'b1, "dev_r_ack");
        cyc(Q);
        sda_m = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        cyc(H / 2);
        check("rst_pre_oe", sda_oe_o, 1);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_oe", sda_oe_o, 0);
        rst = 1'b0;
        ref_ptr = 0;
        cyc(H / 2);
        scl_m = 1'b0;
        stop_c;
        do_read(1, "rst_cur_rd");

        // Current-address read after a single-byte write
        do_write(8'h20, 32'h33, 1);
        do_read(1, "cur_rd");

        // Randomized traffic against the reference model
        for (int r = 0; r < 16; r++) begin
            a = $urandom_range(0, 255);
            n = $urandom_range(1, 4);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a[7:0], d, n);
            end else if (r % 3 == 0) begin
                do_read(n, "rnd_cur_rd");
            end else begin
                set_ptr(a[7:0]);
                do_read(n, "rnd_rd");
            end
        end

        for (int k = 0; k < 200 && obs_q.size() > 0; k++) cyc(1);
        cyc(2);
        check("unmatched_expectations", exp_q.size(), 0);
        s = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
